// File: rtl/mips_bus_arbiter_pkg.sv
// Shared types and constants for the MIPS Avalon bus arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_t;

    localparam logic [3:0] BYTEEN_WORD = 4'b1111;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// Avalon-MM master port shared by fetch and data requesters.
interface mips_bus_arbiter_if;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );

endinterface

// File: rtl/mips_bus_arbiter_timeout_counter.sv
// Counts consecutive stalled bus cycles; expired fires on the stalled
// cycle that brings the count to TIMEOUT_CYCLES.
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Stall counter, cleared at each grant, saturating at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = inc && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between instruction
// fetch and data access. Optional stall timeout: MIPS_BUS_ARB_TIMEOUT_EN.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      if_req,
    input  logic [31:0]               if_addr,
    output logic                      if_done,
    output logic [31:0]               if_rdata,
    input  logic                      d_req,
    input  logic                      d_write,
    input  logic [31:0]               d_addr,
    input  logic [31:0]               d_wdata,
    input  logic [3:0]                d_byteenable,
    output logic                      d_done,
    output logic [31:0]               d_rdata,
    output logic                      busy,
    output logic                      bus_timeout,
    mips_bus_arbiter_if.master        bus
);

    arb_state_t  state_q, state_d;
    grant_t      last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        tmo_expired;
    logic        unused_ok;

    // Byte-offset bits of the fetch address never reach the bus.
    assign unused_ok = ^{if_addr[1:0], (TIMEOUT_CYCLES == 0)};

    // State and registered bus outputs; reset abandons any transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
            addr_q       <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            read_q       <= read_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Arbitration in IDLE, bus hold while stalled, capture on completion.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        read_d       = read_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            IDLE: begin
                // last_grant tracks every grant so a tie alternates owners.
                if (if_req && (!d_req || last_grant_q == GRANT_D)) begin
                    state_d      = BUS_I;
                    last_grant_d = GRANT_IF;
                    addr_d       = {if_addr[31:2], 2'b00};
                    read_d       = 1'b1;
                    write_d      = 1'b0;
                    be_d         = BYTEEN_WORD;
                end else if (d_req) begin
                    state_d      = BUS_D;
                    last_grant_d = GRANT_D;
                    addr_d       = d_addr;
                    read_d       = !d_write;
                    write_d      = d_write;
                    be_d         = d_byteenable;
                    if (d_write) wdata_d = d_wdata;
                end
            end
            BUS_I, BUS_D: begin
                if (!bus.waitrequest || tmo_expired) begin
                    state_d = RESP;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    // A timed-out read returns zero rather than stale bus data.
                    if (state_q == BUS_I)
                        if_rdata_d = bus.waitrequest ? 32'h0 : bus.readdata;
                    else if (read_q)
                        d_rdata_d = bus.waitrequest ? 32'h0 : bus.readdata;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MIPS_BUS_ARB_TIMEOUT_EN
    logic timeout_q;
    logic grant_any;
    logic stalled;

    assign grant_any = (state_q == IDLE) && (if_req || d_req);
    assign stalled   = ((state_q == BUS_I) || (state_q == BUS_D)) && bus.waitrequest;

    bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (grant_any),
        .inc     (stalled),
        .expired (tmo_expired)
    );

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           timeout_q <= 1'b0;
        else if (tmo_expired) timeout_q <= 1'b1;
    end

    assign bus_timeout = timeout_q;
`else
    assign tmo_expired = 1'b0;
    assign bus_timeout = 1'b0;
`endif

    assign bus.address    = addr_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.writedata  = wdata_q;
    assign bus.byteenable = be_q;

    assign if_done  = (state_q == RESP) && (last_grant_q == GRANT_IF);
    assign d_done   = (state_q == RESP) && (last_grant_q == GRANT_D);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed and randomized checks of mips_bus_arbiter against a
// transaction-level model of the arbitration and latency rules.
module tb_mips_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteenable;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        busy;
    logic        bus_timeout;

    mips_bus_arbiter_if bus();

    mips_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_done      (if_done),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_byteenable (d_byteenable),
        .d_done       (d_done),
        .d_rdata      (d_rdata),
        .busy         (busy),
        .bus_timeout  (bus_timeout),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: last owner (1 = data) and the values outputs should hold.
    bit          m_last_d;
    logic [31:0] m_if_rdata;
    logic [31:0] m_d_rdata;
    logic [31:0] m_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_d   = 1'b1;
        m_if_rdata = '0;
        m_d_rdata  = '0;
        m_wdata    = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction from an IDLE cycle with requests already driven.
    // keep: winner holds req through RESP; early: winner drops req after grant.
    task automatic run_txn(input int waits, input logic [31:0] rdat, input bit keep, input bit early);
        bit          g_if;
        logic [31:0] ea;
        logic        er, ew;
        logic [3:0]  eb;
        g_if = (if_req && d_req) ? m_last_d : if_req;
        m_last_d = !g_if;
        if (g_if) begin
            ea = {if_addr[31:2], 2'b00}; er = 1'b1; ew = 1'b0; eb = 4'hF;
        end else begin
            ea = d_addr; er = !d_write; ew = d_write; eb = d_byteenable;
            if (d_write) m_wdata = d_wdata;
        end
        bus.waitrequest = 1'b1;
        bus.readdata    = ~rdat;
        cyc();
        chk("grant_addr", bus.address, ea);
        chk("grant_read", 32'(bus.read), 32'(er));
        chk("grant_write", 32'(bus.write), 32'(ew));
        chk("grant_be", 32'(bus.byteenable), 32'(eb));
        chk("grant_wdata", bus.writedata, m_wdata);
        chk("grant_busy", 32'(busy), 32'd1);
        chk("grant_nodone", 32'({if_done, d_done}), 32'd0);
        if (early) begin
            if (g_if) if_req = 1'b0; else d_req = 1'b0;
        end
        for (int i = 0; i < waits; i++) begin
            bus.waitrequest = 1'b1;
            bus.readdata    = $urandom;
            cyc();
            chk("hold_addr", bus.address, ea);
            chk("hold_strobes", 32'({bus.read, bus.write}), 32'({er, ew}));
            chk("hold_be", 32'(bus.byteenable), 32'(eb));
            chk("hold_nodone", 32'({if_done, d_done}), 32'd0);
        end
        bus.waitrequest = 1'b0;
        bus.readdata    = rdat;
        cyc();
        if (g_if) m_if_rdata = rdat;
        else if (er) m_d_rdata = rdat;
        chk("resp_strobes", 32'({bus.read, bus.write}), 32'd0);
        chk("resp_busy", 32'(busy), 32'd1);
        chk("resp_if_done", 32'(if_done), 32'(g_if));
        chk("resp_d_done", 32'(d_done), 32'(!g_if));
        chk("resp_if_rdata", if_rdata, m_if_rdata);
        chk("resp_d_rdata", d_rdata, m_d_rdata);
        if (!keep) begin
            if (g_if) if_req = 1'b0; else d_req = 1'b0;
        end
        bus.readdata = $urandom;
        cyc();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_nodone", 32'({if_done, d_done}), 32'd0);
        chk("idle_strobes", 32'({bus.read, bus.write}), 32'd0);
        chk("idle_addr_kept", bus.address, ea);
        chk("idle_be_kept", 32'(bus.byteenable), 32'(eb));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, bus.address, 32'h0);
        chk({tag, "_strobes"}, 32'({bus.read, bus.write}), 32'd0);
        chk({tag, "_wdata"}, bus.writedata, 32'h0);
        chk({tag, "_be"}, 32'(bus.byteenable), 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_d_rdata"}, d_rdata, 32'h0);
        chk({tag, "_done"}, 32'({if_done, d_done}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_timeout"}, 32'(bus_timeout), 32'd0);
    endtask

    task automatic set_data(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        d_req = 1'b1; d_write = wr; d_addr = a; d_wdata = wd; d_byteenable = be;
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_byteenable = '0;
        bus.waitrequest = 1'b0; bus.readdata = '0;
        model_reset();
        #2 reset = 1'b0;
        #5;
        chk_all_zero("reset");
        #11 reset = 1'b1;
        cyc();

        // Fetch, zero wait states, unaligned address.
        if_req = 1'b1; if_addr = 32'hBFC0_0003;
        run_txn(0, 32'h2402_0005, 1'b0, 1'b0);

        // Store with three stall cycles; d_rdata must not move.
        set_data(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
        run_txn(3, 32'h5555_AAAA, 1'b0, 1'b0);

        // Ties alternate owners.
        if_req = 1'b1; if_addr = 32'h0000_0400;
        set_data(1'b0, 32'h0000_2000, 32'h0, 4'hF);
        run_txn(1, 32'h1111_2222, 1'b0, 1'b0);
        run_txn(0, 32'h3333_4444, 1'b0, 1'b0);
        if_req = 1'b1; if_addr = 32'h0000_0408;
        set_data(1'b0, 32'h0000_2004, 32'h0, 4'b1100);
        run_txn(0, 32'h5555_6666, 1'b0, 1'b0);
        run_txn(2, 32'h7777_8888, 1'b0, 1'b0);

        // Load re-requested through RESP: next strobe two cycles after done.
        set_data(1'b0, 32'h0000_3000, 32'h0, 4'hF);
        run_txn(0, 32'hCAFE_0001, 1'b1, 1'b0);
        run_txn(0, 32'hCAFE_0002, 1'b0, 1'b0);

        // Request dropped mid-transfer still completes.
        set_data(1'b0, 32'h0000_3004, 32'h0, 4'b0001);
        run_txn(2, 32'hCAFE_0003, 1'b0, 1'b1);

        // Asynchronous reset while a load is stalled.
        set_data(1'b0, 32'h0000_4000, 32'h0, 4'hF);
        bus.waitrequest = 1'b1;
        cyc();
        chk("pre_reset_read", 32'(bus.read), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        d_req = 1'b0;
        cyc();
        cyc();
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_reset_nodone", 32'({if_done, d_done}), 32'd0);
            chk("post_reset_busy", 32'(busy), 32'd0);
        end

        // Tie right after reset goes to fetch.
        if_req = 1'b1; if_addr = 32'h0000_0010;
        set_data(1'b0, 32'h0000_5000, 32'h0, 4'hF);
        run_txn(0, 32'hABCD_0001, 1'b0, 1'b0);
        run_txn(1, 32'hABCD_0002, 1'b0, 1'b0);

        // Randomized traffic; a losing requester stays pending.
        for (int t = 0; t < 60; t++) begin
            if (!if_req && ($urandom_range(0, 1) == 1)) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (!d_req && (($urandom_range(0, 1) == 1) || !if_req))
                set_data(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            run_txn(int'($urandom_range(0, 4)), $urandom, 1'b0, ($urandom_range(0, 3) == 0));
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        cyc();
        cyc();
        chk("final_busy", 32'(busy), 32'd0);

`ifdef MIPS_BUS_ARB_TIMEOUT_EN
        // Stuck waitrequest: done after eight stalled cycles with zero data.
        set_data(1'b0, 32'h0000_6000, 32'h0, 4'hF);
        bus.waitrequest = 1'b1;
        cyc();
        chk("tmo_read", 32'(bus.read), 32'd1);
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("tmo_nodone", 32'(d_done), 32'd0);
        end
        cyc();
        chk("tmo_done", 32'(d_done), 32'd1);
        chk("tmo_rdata", d_rdata, 32'h0);
        chk("tmo_strobes", 32'({bus.read, bus.write}), 32'd0);
        chk("tmo_flag", 32'(bus_timeout), 32'd1);
        d_req = 1'b0;
        bus.waitrequest = 1'b0;
        cyc();
        cyc();
        chk("tmo_sticky", 32'(bus_timeout), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("tmo_reset", 32'(bus_timeout), 32'd0);
        #4 reset = 1'b1;
`else
        chk("no_timeout_flag", 32'(bus_timeout), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the single Avalon memory-mapped master port of the bus CPU between two requesters: instruction fetch (PC/fetch phase) and data access (load/store unit in exec phases).
- Registers all bus outputs, holds them stable while waitrequest is high, captures readdata, and returns a one-cycle done pulse to the winning requester.
- Uses round-robin arbitration when both requesters are pending in the same cycle.

Parameters:
- TIMEOUT_CYCLES, 256, number of consecutive waitrequest-high cycles before a timeout (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held high until if_done.
- if_addr  input  32  fetch byte address; bits [1:0] are ignored and forced to 0 on the bus.
- if_done  output  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  output  32  fetched instruction word; held until the next fetch completes.
- d_req  input  1  data request; held high until d_done.
- d_write  input  1  1 = store, 0 = load; sampled at grant.
- d_addr  input  32  data word address.
- d_wdata  input  32  store data.
- d_byteenable  input  4  lane enables for load/store.
- d_done  output  1  one-cycle pulse: data access complete.
- d_rdata  output  32  load data; held until the next load completes.
- busy  output  1  high in any state other than IDLE.
- bus_timeout  output  1  sticky timeout flag (see Optional Feature).
- address  output  32  Avalon address.
- read  output  1  Avalon read strobe.
- write  output  1  Avalon write strobe.
- writedata  output  32  Avalon write data.
- byteenable  output  4  Avalon byte enables.
- waitrequest  input  1  Avalon stall.
- readdata  input  32  Avalon read data; valid in the cycle that read=1 and waitrequest=0.

Behaviour:
- Reset (asynchronous, while reset=0):
  - State goes to IDLE and last_grant to DATA, so fetch wins the first tie.
  - All outputs go to 0: address, read, write, writedata, byteenable, if_rdata, d_rdata, done pulses, busy, bus_timeout.
  - An in-flight transaction is abandoned and no done pulse is issued.
- States:
  - IDLE -> BUS_I or BUS_D on a request.
  - BUS_I / BUS_D -> RESP on completion.
  - RESP -> IDLE.
- IDLE arbitration:
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant the requester that is not last_grant, then update last_grant.
  - Requests are sampled only in IDLE.
- Grant edge (registered outputs):
  - Fetch: address = {if_addr[31:2], 2'b00}, read = 1, byteenable = 4'b1111.
  - Data load: address = d_addr, read = 1, byteenable = d_byteenable.
  - Data store: address = d_addr, write = 1, writedata = d_wdata, byteenable = d_byteenable.
  - read and write are never both 1.
- BUS_x:
  - While waitrequest = 1, all bus outputs are held unchanged.
  - The first cycle with waitrequest = 0 completes the transfer.
  - On that edge: read and write are cleared, readdata is captured into if_rdata (fetch) or d_rdata (load), and state goes to RESP. d_rdata is unchanged on a store.
- RESP:
  - The matching done output is 1 for exactly this cycle; busy stays 1.
  - The requester must drop its req in this cycle. Requests are ignored in RESP, so the next grant is possible one cycle later from IDLE.
- Latency:
  - Request seen in IDLE at cycle 0; bus strobe in cycle 1.
  - With zero wait states, done in cycle 2 and IDLE in cycle 3.
  - Each waitrequest cycle adds 1 cycle.
- Request dropped mid-transfer: the bus transfer still completes and done still pulses (no bus abort).
- address, writedata and byteenable keep their last values when idle; only the strobes return to 0.

Optional Feature:
- Macro: MIPS_BUS_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears at grant and increments each BUS_x cycle with waitrequest = 1.
  - When it reaches TIMEOUT_CYCLES, the strobes drop, state goes to RESP, and done pulses with rdata forced to 0.
  - bus_timeout is set and stays set until reset.
- Without the macro: no counter is built, bus_timeout is tied to 0, and waits are unbounded.

Decomposition:
- Package mips_bus_pkg:
  - arb_state_t enum {IDLE, BUS_I, BUS_D, RESP}.
  - grant_t enum {GRANT_IF, GRANT_D}.
  - Constant BYTEEN_WORD = 4'b1111.
- Sub-module bus_timeout_counter (clk, reset, clear, inc, expired), instantiated only under MIPS_BUS_ARB_TIMEOUT_EN.

Test Plan:
- Fetch with zero wait states: if_req=1, if_addr=0xBFC00003, readdata=0x24020005 -> cycle 1: address=0xBFC00000, read=1, byteenable=4'hF; cycle 2: if_done=1, if_rdata=0x24020005.
- Store with three waitrequest cycles: d_req=1, d_write=1, d_addr=0x1000, d_wdata=0xDEADBEEF, d_byteenable=4'b0011 -> write and bus fields held for 4 cycles; d_done exactly 1 cycle after waitrequest falls; d_rdata unchanged.
- Simultaneous if_req and d_req after reset -> fetch granted first; data granted after the fetch RESP; next tie goes to fetch again.
- Assert reset=0 during BUS_D with waitrequest=1 -> all outputs 0 immediately (asynchronous); after release, state is IDLE and no done pulse occurs.
- Load followed by an immediate re-request held through RESP -> no grant in the RESP cycle; second bus strobe appears 2 cycles after the first done.
- With MIPS_BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, waitrequest stuck at 1 -> done after 8 wait cycles, d_rdata=0, bus_timeout stays 1 until reset.
